// File: rtl/fb_writer.sv
// fb_writer: frame-buffer writer. It accepts an 8-bit pixel stream over a
// valid/ready handshake and writes one frame sequentially into the write port
// of the frame RAM, starting at BASE_ADDR. Addresses wrap modulo 2^ADDR_W.
//
// Handshake: a pixel transfers on every rising edge where in_valid and
// in_ready are both 1. in_ready depends only on the FSM state, never on
// in_valid. An asserted abort suppresses the transfer in that cycle, even
// though in_ready still reads 1.
//
// Optional feature macro: FB_VSYNC_ALIGN_EN. When it is defined, an ARM state
// and a 2-flop vsync synchronizer with falling-edge detect are compiled in, so
// that a frame starts only at the start of vertical sync. When it is not
// defined, vsync is ignored and start goes straight to WRITE.
//
// dbg_state_o exposes the FSM state for observation (IDLE=0, ARM=1, WRITE=2,
// DONE=3).
module fb_writer #(
  parameter int ADDR_W    = 16,
  parameter int FRAME_LEN = 65536,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              vsync,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [7:0]        writeData,
  output logic              writeEnable,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        data_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;

`ifdef FB_VSYNC_ALIGN_EN
  logic vs_meta_q;
  logic vs_sync_q;
  logic vs_prev_q;
  logic vs_fall;

  // vsync is asynchronous to clk: two synchronizer flops, then one flop that
  // holds the previous synchronized value for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign vs_fall = vs_prev_q & ~vs_sync_q;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
`endif

  // Next pixel count and the write address of the pixel being accepted
  // (the address wraps naturally at 2^ADDR_W).
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    addr_d = BASE + cnt_q[ADDR_W-1:0];
  end

  // Frame FSM: every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (start && !abort) begin
`ifdef FB_VSYNC_ALIGN_EN
            state_q <= ST_ARM;
`else
            state_q <= ST_WRITE;
`endif
            busy_q <= 1'b1;
          end
        end
`ifdef FB_VSYNC_ALIGN_EN
        ST_ARM: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (vs_fall) begin
            state_q <= ST_WRITE;
          end
        end
`endif
        ST_WRITE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (in_valid) begin
            we_q   <= 1'b1;
            data_q <= in_data;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            if (cnt_q == LAST) begin
              // The final write and done appear together in the DONE cycle.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = (state_q == ST_WRITE);
  assign writeAddress = addr_q;
  assign writeData    = data_q;
  assign writeEnable  = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dbg_state_o  = state_q;

endmodule
